// File: rtl/ysyx_22050039_ifu_pkg.sv
// Shared definitions for the instruction fetch unit and the decode/execute stages
// that consume its fault codes and reset address.
package ysyx_22050039_ifu_pkg;

   typedef enum logic [1:0] {
      S_REQ       = 2'd0,
      S_WAIT_RESP = 2'd1,
      S_HOLD      = 2'd2,
      S_WAIT_EXEC = 2'd3
   } ifu_state_e;

   typedef logic [1:0] fault_t;

   localparam fault_t FAULT_NONE     = 2'd0;
   localparam fault_t FAULT_MISALIGN = 2'd1;
   localparam fault_t FAULT_BUS      = 2'd2;
   localparam fault_t FAULT_TIMEOUT  = 2'd3;

   localparam logic [63:0] IFU_RESET_PC = 64'h8000_0000;
   localparam int          WAIT_CNT_W   = 9;

   function automatic logic pc_aligned(input logic [1:0] pc_lsb);
      return pc_lsb == 2'b00;
   endfunction

endpackage

// File: rtl/ysyx_22050039_ifu_waitcnt.sv
// Response wait counter: counts idle WAIT_RESP cycles and flags when the limit is reached.
module ysyx_22050039_WaitCnt
   import ysyx_22050039_ifu_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [WAIT_CNT_W-1:0] cnt;

   // Saturates at the limit so expired stays asserted until the owner clears it.
   always_ff @(posedge clk) begin
      if (!rst || clear) begin
         cnt <= '0;
      end else if (enable && !expired) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expired = (cnt == WAIT_CNT_W'(TIMEOUT));

endmodule

// File: rtl/ysyx_22050039_ifu.sv
// Instruction fetch unit: one outstanding imem request, holds the fetched word for decode,
// then waits for execute to report the next PC.
module ysyx_22050039_ifu
   import ysyx_22050039_ifu_pkg::*;
#(
   parameter int              XLEN     = 64,
   parameter logic [XLEN-1:0] RESET_PC = IFU_RESET_PC[XLEN-1:0],
   parameter int              TIMEOUT  = 255
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   output logic            imem_resp_ready,
   input  logic            imem_resp_valid,
   input  logic [31:0]     imem_resp_data,
   input  logic            imem_resp_err,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [31:0]     inst,
   output logic [XLEN-1:0] inst_pc,
   output logic [1:0]      inst_fault,
   input  logic            exec_done,
   input  logic            exec_jump,
   input  logic [XLEN-1:0] exec_dnpc,
   output ifu_state_e      dbg_state
);

   // Handshakes (imem request, imem response, inst to decode): a transfer happens on a
   // posedge where valid and ready are both high; once valid rises it stays high with a
   // stable payload until that transfer. All valid/ready outputs are forced low while rst=0.

   ifu_state_e      state, next_state;
   logic [XLEN-1:0] pc;
   logic [31:0]     inst_r;
   fault_t          fault_r;
   logic            aligned;
   logic            timed_out;
   logic            req_fire, resp_fire, inst_fire;

   assign aligned   = pc_aligned(pc[1:0]);
   assign req_fire  = imem_req_valid && imem_req_ready;
   assign resp_fire = imem_resp_ready && imem_resp_valid;
   assign inst_fire = inst_valid && inst_ready;

   ysyx_22050039_WaitCnt #(
      .TIMEOUT(TIMEOUT)
   ) u_wait_cnt (
      .clk    (clk),
      .rst    (rst),
      .clear  (state != S_WAIT_RESP),
      .enable ((state == S_WAIT_RESP) && !imem_resp_valid),
      .expired(timed_out)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= S_REQ;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         S_REQ: begin
            if (!aligned) begin
               next_state = S_HOLD;
            end else if (req_fire) begin
               next_state = S_WAIT_RESP;
            end
         end
         S_WAIT_RESP: begin
            // A response in the expiry cycle still wins over the timeout.
            if (resp_fire || timed_out) begin
               next_state = S_HOLD;
            end
         end
         S_HOLD: begin
            if (inst_fire) begin
               next_state = S_WAIT_EXEC;
            end
         end
         S_WAIT_EXEC: begin
            if (exec_done) begin
               next_state = S_REQ;
            end
         end
         default: next_state = S_REQ;
      endcase
   end

   always_comb begin
      imem_req_valid  = rst && (state == S_REQ) && aligned;
      imem_resp_ready = rst && (state == S_WAIT_RESP);
      inst_valid      = rst && (state == S_HOLD);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pc      <= RESET_PC;
         inst_r  <= '0;
         fault_r <= FAULT_NONE;
      end else begin
         case (state)
            S_REQ: begin
               if (!aligned) begin
                  inst_r  <= '0;
                  fault_r <= FAULT_MISALIGN;
               end
            end
            S_WAIT_RESP: begin
               if (resp_fire) begin
                  inst_r  <= imem_resp_data;
                  fault_r <= imem_resp_err ? FAULT_BUS : FAULT_NONE;
               end else if (timed_out) begin
                  inst_r  <= '0;
                  fault_r <= FAULT_TIMEOUT;
               end
            end
            S_WAIT_EXEC: begin
               if (exec_done) begin
                  pc <= exec_jump ? exec_dnpc : pc + XLEN'(4);
               end
            end
            default: ;
         endcase
      end
   end

   assign imem_req_addr = pc;
   assign inst          = inst_r;
   assign inst_pc       = pc;
   assign inst_fault    = fault_r;
   assign dbg_state     = state;

endmodule

// File: doc/ysyx_22050039_ifu.md
YSYX_22050039_IFU -- requirements
Module: ysyx_22050039_IFU

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath and PC width.
REQ-002 SHALL have parameter RESET_PC, default 64'h8000_0000, first fetch address.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum cycles waiting for an imem response.
REQ-004 clk  in  1  clock; all state updates on posedge.
REQ-005 rst  in  1  reset: synchronous, active-low.
REQ-006 imem_req_valid  out  1  fetch request valid.
REQ-007 imem_req_ready  in  1  memory accepts the request.
REQ-008 imem_req_addr  out  XLEN  fetch address, equal to the current PC.
REQ-009 imem_resp_ready  out  1  IFU accepts a response; high only in WAIT_RESP.
REQ-010 imem_resp_valid  in  1  response valid.
REQ-011 imem_resp_data  in  32  instruction word.
REQ-012 imem_resp_err  in  1  bus error for this response.
REQ-013 inst_valid  out  1  instruction offered to decode.
REQ-014 inst_ready  in  1  decode accepts the instruction.
REQ-015 inst  out  32  instruction word.
REQ-016 inst_pc  out  XLEN  PC of inst; this is the pc consumed by execute.
REQ-017 inst_fault  out  2  0 none, 1 misaligned PC, 2 bus error, 3 timeout.
REQ-018 exec_done  in  1  execute has finished the delivered instruction.
REQ-019 exec_jump  in  1  with exec_done: next PC is exec_dnpc.
REQ-020 exec_dnpc  in  XLEN  redirect target produced by execute.

Function
REQ-021 FSM states SHALL be REQ, WAIT_RESP, HOLD and WAIT_EXEC; no other states.
REQ-022 REQ: imem_req_valid=1 while PC[1:0]==0; on req_valid&&req_ready go to WAIT_RESP the next cycle.
REQ-023 REQ with PC[1:0]!=0: no request is issued; go to HOLD with inst=0 and fault=1.
REQ-024 While req_valid=1 and req_ready=0, imem_req_addr SHALL stay stable, and req_valid SHALL NOT drop.
REQ-025 WAIT_RESP: on resp_valid, latch resp_data into inst and go to HOLD; fault=2 if resp_err, else 0.
REQ-026 WAIT_RESP: a 9-bit wait counter clears on entry and increments each cycle without a response; when it reaches TIMEOUT, go to HOLD with inst=0 and fault=3.
REQ-027 A response in the same cycle the counter reaches TIMEOUT SHALL take priority over the timeout.
REQ-028 Responses arriving outside WAIT_RESP SHALL be ignored and SHALL NOT alter state.
REQ-029 HOLD: inst_valid=1; inst, inst_pc and inst_fault SHALL stay stable until inst_ready; on inst_valid&&inst_ready go to WAIT_EXEC.
REQ-030 WAIT_EXEC: on exec_done go to REQ; PC becomes exec_dnpc if exec_jump, else PC+4 (mod 2^XLEN wrap).
REQ-031 exec_done outside WAIT_EXEC SHALL be ignored.
REQ-032 Minimum round trip with a zero-wait memory and decode: REQ(1) + WAIT_RESP(1) + HOLD(1) + WAIT_EXEC(>=1) = 4 cycles per instruction.
REQ-033 At most one imem request SHALL be outstanding at any time.

Reset
REQ-034 When rst=0 at posedge: state=REQ, PC=RESET_PC, inst=0, inst_fault=0, wait counter=0.
REQ-035 During reset and the cycle it is applied, all valid/ready outputs SHALL be 0; a response pending across reset SHALL be dropped.
REQ-036 First request SHALL appear in the first cycle after rst returns high.

Structure
REQ-037 A shared package SHALL hold the FSM state enum, the fault-code constants and the RESET_PC default; execute and decode SHALL import the same package.
REQ-038 The timeout counter SHALL be a sub-module ysyx_22050039_WaitCnt (clear, enable, expired); everything else stays in one module.

Verification
REQ-039 Reset release, zero-wait memory returning 32'h00000413, inst_ready=1, exec_done with jump=0 -> request addr 0x80000000 in cycle 1, inst_valid in cycle 3, next request addr 0x80000004.
REQ-040 Memory holds req_ready=0 for 3 cycles -> addr stays 0x80000000 and req_valid stays 1 throughout; exactly one request is accepted.
REQ-041 Decode holds inst_ready=0 for 5 cycles -> inst and inst_pc are unchanged; no new request is issued.
REQ-042 exec_jump=1 with dnpc=0x80000102 -> next cycle state=REQ and no request; HOLD with fault=1 and inst=0.
REQ-043 No response for 255 cycles -> fault=3; a response with resp_err=1 -> fault=2; a late response after the timeout is ignored.
REQ-044 rst asserted during WAIT_RESP, then a response arrives -> state REQ, PC=0x80000000, and the response is discarded.
